ifetch_queue: RTL

Instruction-fetch front end for the 16-bit core. It generates sequential fetch addresses, issues requests to a synchronous instruction memory over a request/grant/response handshake, and buffers returned instruction words in a small in-order prefetch queue. It presents them to decode with their PC under a valid/ready handshake. Decode redirects it on taken branch or jump, which flushes all queued and in-flight fetches.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ifq_fifo.sv | 69 ++++++
 rtl/ifetch_queue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, reset vector and fetch-entry type for the core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W     = 16;
    localparam int INST_W     = 16;
    localparam logic [ADDR_W-1:0] PC_RESET = 16'h0000;
    localparam int INST_BYTES = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifq_fifo
// Description : Synchronous FIFO with occupancy count and clear; DEPTH must be
//               a power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int c_PTR_W = $clog2(DEPTH),
    localparam int c_CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic [c_CNT_W-1:0] count
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_en;
    logic               w_rd_en;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
    assign w_wr_en = push & (~w_full | pop);
    assign w_rd_en = pop & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_wr_en) - c_CNT_W'(w_rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !clear) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction-fetch front end: credit-limited sequential fetch,
//               in-order prefetch queue, redirect flush with stale-response
//               discard. Optional IFETCH_BYPASS_EN forwards a response straight
//               to decode when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INST_W = cpu_pkg::INST_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_OCC_W = c_CNT_W + 2;
    localparam int c_ENT_W = ADDR_W + INST_W;
    localparam logic [ADDR_W-1:0] c_PC_RESET   = ADDR_W'(cpu_pkg::PC_RESET);
    localparam logic [ADDR_W-1:0] c_PC_STEP    = ADDR_W'(cpu_pkg::INST_BYTES);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(1);

    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [c_CNT_W-1:0] r_discard;

    logic [c_CNT_W-1:0] w_q_count;
    logic [c_CNT_W-1:0] w_pc_count;
    logic [c_ENT_W-1:0] w_q_head;
    logic [ADDR_W-1:0]  w_pc_head;
    logic               w_grant;
    logic               w_resp_live;
    logic               w_resp_drop;
    logic               w_q_empty;
    logic               w_bypass;
    logic               w_q_push;
    logic               w_q_pop;
    logic [c_OCC_W-1:0] w_q_nxt;
    logic [c_OCC_W-1:0] w_pc_nxt;
    logic [c_OCC_W-1:0] w_disc_nxt;
    logic [c_OCC_W-1:0] w_occ_nxt;
    logic               w_req_nxt;
    logic [ADDR_W-1:0]  w_fetch_pc_nxt;

    assign w_grant     = r_mem_req & mem_gnt;
    // Responses owed to pre-redirect grants are dropped while the discard count is nonzero.
    assign w_resp_live = mem_rvalid & ~redirect & (r_discard == '0);
    assign w_resp_drop = mem_rvalid & ~redirect & (r_discard != '0);
    assign w_q_empty   = (w_q_count == '0);

`ifdef IFETCH_BYPASS_EN
    assign w_bypass = w_q_empty & w_resp_live;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_q_push = w_resp_live & ~(w_bypass & inst_ready);
    assign w_q_pop  = ~w_q_empty & inst_ready & ~redirect;

    ifq_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (w_grant),
        .push_data (r_fetch_pc),
        .pop       (w_resp_live),
        .pop_data  (w_pc_head),
        .count     (w_pc_count)
    );

    ifq_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (w_q_push),
        .push_data ({w_pc_head, mem_rdata}),
        .pop       (w_q_pop),
        .pop_data  (w_q_head),
        .count     (w_q_count)
    );

    always_comb begin
        w_q_nxt        = c_OCC_W'(w_q_count) + c_OCC_W'(w_q_push) - c_OCC_W'(w_q_pop);
        w_pc_nxt       = c_OCC_W'(w_pc_count) + c_OCC_W'(w_grant) - c_OCC_W'(w_resp_live);
        w_disc_nxt     = c_OCC_W'(r_discard) - c_OCC_W'(w_resp_drop);
        w_fetch_pc_nxt = w_grant ? (r_fetch_pc + c_PC_STEP) : r_fetch_pc;
        if (redirect) begin
            // Everything still owed by memory becomes stale, including this cycle's grant.
            w_disc_nxt     = c_OCC_W'(r_discard) + c_OCC_W'(w_pc_count)
                           + c_OCC_W'(w_grant) - c_OCC_W'(mem_rvalid);
            w_q_nxt        = '0;
            w_pc_nxt       = '0;
            w_fetch_pc_nxt = redirect_pc & c_ALIGN_MASK;
        end
        w_occ_nxt = w_q_nxt + w_pc_nxt + w_disc_nxt;

        if (redirect) begin
            w_req_nxt = 1'b0;
        end else if (r_mem_req && !mem_gnt) begin
            w_req_nxt = 1'b1;
        end else begin
            w_req_nxt = (w_occ_nxt < c_OCC_W'(DEPTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req  <= 1'b0;
            r_fetch_pc <= c_PC_RESET;
            r_discard  <= '0;
        end else begin
            r_mem_req  <= w_req_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_discard  <= w_disc_nxt[c_CNT_W-1:0];
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_fetch_pc;

    always_comb begin
        inst_valid = ~w_q_empty;
        inst       = w_q_head[INST_W-1:0];
        inst_pc    = w_q_head[c_ENT_W-1:INST_W];
        if (w_q_empty) begin
            inst    = '0;
            inst_pc = '0;
        end
`ifdef IFETCH_BYPASS_EN
        if (w_bypass) begin
            inst_valid = 1'b1;
            inst       = mem_rdata;
            inst_pc    = w_pc_head;
        end
`endif
    end

endmodule
`default_nettype wire
